// File: rtl/mdu_sequencer.sv
// Multiply/divide unit sequencer: launches MULT/MULTU/DIV/DIVU, waits for completion and writes HI/LO.
// Optional macro MDU_DIV0_TRAP_EN: DIV/DIVU accepted with divisor_zero=1 trap straight to ERR.
module mdu_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] req_op,
  output logic       req_ready,
  input  logic       divisor_zero,
  input  logic       mul_done,
  input  logic       mulu_done,
  input  logic       div_busy,
  input  logic       divu_busy,
  output logic       mul_start,
  output logic       mulu_start,
  output logic       div_start,
  output logic       divu_start,
  output logic       hi_ena,
  output logic       lo_ena,
  output logic [2:0] hi_sel,
  output logic [2:0] lo_sel,
  output logic       mdu_busy,
  output logic       op_done,
  output logic       op_err
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    WB     = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t     state;
  logic [2:0] op;
  logic [7:0] cnt;
  logic       complete;
  logic       div0_trap;

  assign req_ready = (state == IDLE);
  assign mdu_busy  = (state != IDLE);

  always_comb begin
    complete = 1'b0;
    case (op)
      OP_MULT:  complete = mul_done;
      OP_MULTU: complete = mulu_done;
      OP_DIV:   complete = ~div_busy;
      OP_DIVU:  complete = ~divu_busy;
      default:  complete = 1'b0;
    endcase
  end

`ifdef MDU_DIV0_TRAP_EN
  assign div0_trap = divisor_zero & ((req_op == OP_DIV) | (req_op == OP_DIVU));
`else
  assign div0_trap = 1'b0;
`endif

  // HI/LO source mux code for a given op; MTHI/MTLO and illegal ops select Rs.
  function automatic logic [2:0] sel_of(input logic [2:0] o);
    case (o)
      OP_MULT:  sel_of = 3'b011;
      OP_MULTU: sel_of = 3'b100;
      OP_DIV:   sel_of = 3'b001;
      OP_DIVU:  sel_of = 3'b010;
      default:  sel_of = 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op         <= 3'b000;
      cnt        <= 8'd0;
      mul_start  <= 1'b0;
      mulu_start <= 1'b0;
      div_start  <= 1'b0;
      divu_start <= 1'b0;
      hi_ena     <= 1'b0;
      lo_ena     <= 1'b0;
      hi_sel     <= 3'b000;
      lo_sel     <= 3'b000;
      op_done    <= 1'b0;
      op_err     <= 1'b0;
    end else begin
      mul_start  <= 1'b0;
      mulu_start <= 1'b0;
      div_start  <= 1'b0;
      divu_start <= 1'b0;
      hi_ena     <= 1'b0;
      lo_ena     <= 1'b0;
      op_done    <= 1'b0;
      op_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op     <= req_op;
            hi_sel <= sel_of(req_op);
            lo_sel <= sel_of(req_op);
            if (div0_trap) begin
              state  <= ERR;
              op_err <= 1'b1;
            end else begin
              case (req_op)
                OP_MULT:  begin state <= LAUNCH; mul_start  <= 1'b1; end
                OP_MULTU: begin state <= LAUNCH; mulu_start <= 1'b1; end
                OP_DIV:   begin state <= LAUNCH; div_start  <= 1'b1; end
                OP_DIVU:  begin state <= LAUNCH; divu_start <= 1'b1; end
                OP_MTHI:  begin state <= WB; hi_ena <= 1'b1; op_done <= 1'b1; end
                OP_MTLO:  begin state <= WB; lo_ena <= 1'b1; op_done <= 1'b1; end
                default:  begin state <= ERR; op_err <= 1'b1; end
              endcase
            end
          end
        end
        LAUNCH: begin
          state <= WAIT;
          cnt   <= 8'd0;
        end
        WAIT: begin
          // The first WAIT cycle (cnt==0) ignores flags left over from a previous operation.
          if ((cnt != 8'd0) && complete) begin
            state   <= WB;
            hi_ena  <= 1'b1;
            lo_ena  <= 1'b1;
            op_done <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state  <= ERR;
            op_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WB, ERR: begin
          state  <= IDLE;
          cnt    <= 8'd0;
          hi_sel <= 3'b000;
          lo_sel <= 3'b000;
        end
        default: begin
          state  <= IDLE;
          hi_sel <= 3'b000;
          lo_sel <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer (TIMEOUT=8): vector table of single operations plus hand-written sequences.
module tb_mdu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_op;
  logic       req_ready;
  logic       divisor_zero;
  logic       mul_done, mulu_done, div_busy, divu_busy;
  logic       mul_start, mulu_start, div_start, divu_start;
  logic       hi_ena, lo_ena;
  logic [2:0] hi_sel, lo_sel;
  logic       mdu_busy, op_done, op_err;

  int tests = 0;
  int fails = 0;

  mdu_sequencer #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .divisor_zero(divisor_zero), .mul_done(mul_done), .mulu_done(mulu_done),
    .div_busy(div_busy), .divu_busy(divu_busy), .mul_start(mul_start), .mulu_start(mulu_start),
    .div_start(div_start), .divu_start(divu_start), .hi_ena(hi_ena), .lo_ena(lo_ena),
    .hi_sel(hi_sel), .lo_sel(lo_sel), .mdu_busy(mdu_busy), .op_done(op_done), .op_err(op_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic       dz;
    int         done_cyc;   // first cycle the unit reports completion (cycle 0 is stale-complete)
    int         exp_start;  // -1: no start pulse
    int         exp_id;     // 0 mul,1 mulu,2 div,3 divu
    int         exp_write;  // -1: no write
    int         exp_err;    // -1: no error
    logic       exp_hi;
    logic       exp_lo;
    logic [2:0] exp_sel;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [2:0] o, input logic dz, input int dc,
                              input int st, input int id, input int wr, input int er,
                              input logic h, input logic l, input logic [2:0] s);
    vec_t v;
    v.name = n; v.op = o; v.dz = dz; v.done_cyc = dc; v.exp_start = st; v.exp_id = id;
    v.exp_write = wr; v.exp_err = er; v.exp_hi = h; v.exp_lo = l; v.exp_sel = s;
    return v;
  endfunction

  function automatic logic [13:0] outs();
    return {mul_start, mulu_start, div_start, divu_start, hi_ena, lo_ena,
            hi_sel, lo_sel, op_done, op_err};
  endfunction

  // Only the unit matching the op follows the scenario; the others look permanently complete.
  task automatic drive_flags(input logic [2:0] op, input logic c);
    mul_done  = (op == 3'b000) ? c : 1'b1;
    mulu_done = (op == 3'b001) ? c : 1'b1;
    div_busy  = (op == 3'b010) ? ~c : 1'b0;
    divu_busy = (op == 3'b011) ? ~c : 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int start_c = -1, start_id = -1, write_c = -1, err_c = -1, ready_c = -1, bad = 0;
    logic hi_s = 1'b0, lo_s = 1'b0;
    logic [2:0] sel_s = 3'b000;
    logic [3:0] s;
    int exp_ready;
    @(negedge clk);
    check({v.name, " ready@0"}, int'(req_ready), 1);
    drive_flags(v.op, 1'b1);
    req_valid = 1'b1; req_op = v.op; divisor_zero = v.dz;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      s = {divu_start, div_start, mulu_start, mul_start};
      if (s != 4'b0000) begin
        if (start_c != -1 || $countones(s) != 1) bad++;
        else begin
          start_c = k;
          start_id = (s == 4'b0001) ? 0 : (s == 4'b0010) ? 1 : (s == 4'b0100) ? 2 : 3;
        end
      end
      if (hi_ena || lo_ena || op_done) begin
        if (write_c != -1 || !op_done) bad++;
        else begin
          write_c = k; hi_s = hi_ena; lo_s = lo_ena; sel_s = hi_ena ? hi_sel : lo_sel;
        end
      end
      if (op_err) begin
        if (err_c != -1) bad++;
        else err_c = k;
      end
      if (req_ready && ready_c == -1) ready_c = k;
      if (mdu_busy == req_ready) bad++;
      // Requests while busy must be ignored and never queued.
      drive_flags(v.op, (k >= v.done_cyc));
      req_valid = mdu_busy; req_op = 3'b100; divisor_zero = 1'b0;
    end
    req_valid = 1'b0;
    exp_ready = ((v.exp_write != -1) ? v.exp_write : v.exp_err) + 1;
    check({v.name, " start_cyc"}, start_c, v.exp_start);
    check({v.name, " start_id"}, start_id, v.exp_id);
    check({v.name, " write_cyc"}, write_c, v.exp_write);
    check({v.name, " err_cyc"}, err_c, v.exp_err);
    check({v.name, " hi/lo"}, int'({hi_s, lo_s}), int'({v.exp_hi, v.exp_lo}));
    check({v.name, " sel"}, int'(sel_s), int'(v.exp_sel));
    check({v.name, " ready_cyc"}, ready_c, exp_ready);
    check({v.name, " protocol"}, bad, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vecs[0]  = mk("MULT",        3'b000, 1'b0, 5,  1, 0, 6,  -1, 1'b1, 1'b1, 3'b011);
    vecs[1]  = mk("MULTU",       3'b001, 1'b0, 6,  1, 1, 7,  -1, 1'b1, 1'b1, 3'b100);
    vecs[2]  = mk("DIV",         3'b010, 1'b0, 4,  1, 2, 5,  -1, 1'b1, 1'b1, 3'b001);
    vecs[3]  = mk("DIVU_mask",   3'b011, 1'b0, 2,  1, 3, 4,  -1, 1'b1, 1'b1, 3'b010);
    vecs[4]  = mk("DIV_tmo",     3'b010, 1'b0, 99, 1, 2, -1, 10, 1'b0, 1'b0, 3'b000);
    vecs[5]  = mk("MTHI",        3'b100, 1'b0, 1,  -1, -1, 1, -1, 1'b1, 1'b0, 3'b000);
    vecs[6]  = mk("MTLO",        3'b101, 1'b0, 1,  -1, -1, 1, -1, 1'b0, 1'b1, 3'b000);
    vecs[7]  = mk("ILL110",      3'b110, 1'b0, 1,  -1, -1, -1, 1, 1'b0, 1'b0, 3'b000);
    vecs[8]  = mk("ILL111",      3'b111, 1'b0, 1,  -1, -1, -1, 1, 1'b0, 1'b0, 3'b000);
    vecs[9]  = mk("MULT_tie",    3'b000, 1'b0, 9,  1, 0, 10, -1, 1'b1, 1'b1, 3'b011);
`ifdef MDU_DIV0_TRAP_EN
    vecs[10] = mk("DIVU_dz",     3'b011, 1'b1, 3,  -1, -1, -1, 1, 1'b0, 1'b0, 3'b000);
`else
    vecs[10] = mk("DIVU_dz",     3'b011, 1'b1, 3,  1, 3, 4,  -1, 1'b1, 1'b1, 3'b010);
`endif
    vecs[11] = mk("MULTU_tmo",   3'b001, 1'b0, 10, 1, 1, -1, 10, 1'b0, 1'b0, 3'b000);

    rst = 1'b1; req_valid = 1'b0; req_op = 3'b000; divisor_zero = 1'b0;
    mul_done = 1'b0; mulu_done = 1'b0; div_busy = 1'b0; divu_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outs", int'(outs()), 0);
    check("reset ready/busy", int'({req_ready, mdu_busy}), 2);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Illegal op followed back-to-back by MTLO.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b111;
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b err@1", int'({op_err, hi_ena, lo_ena}), 4);
    @(negedge clk);
    check("b2b ready@2", int'(req_ready), 1);
    req_valid = 1'b1; req_op = 3'b101;
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b mtlo@3", int'({hi_ena, lo_ena, op_done, lo_sel}), 3 << 3);
    @(negedge clk);

    // Reset in the middle of a MULT wait.
    drive_flags(3'b000, 1'b0);
    req_valid = 1'b1; req_op = 3'b000;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst mult start@1", int'(mul_start), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst mid outs", int'(outs()), 0);
    check("rst mid ready/busy", int'({req_ready, mdu_busy}), 2);
    @(negedge clk);
    check("rst hold outs", int'(outs()), 0);
    rst = 1'b0;
    mul_done = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (outs() != 14'd0 || !req_ready) bad++;
    end
    check("rst no write after", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 64, is the maximum number of WAIT cycles before an operation is aborted; its legal range is 2..255.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  controller requests a multiply/divide/HI-LO operation.
REQ-005 req_op  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are illegal.
REQ-006 req_ready  out  1  high in IDLE only; a request is accepted on a cycle with req_valid & req_ready.
REQ-007 divisor_zero  in  1  the current Rt equals 0; sampled at acceptance.
REQ-008 mul_done, mulu_done  in  1 each  completion flags from the signed and unsigned multipliers.
REQ-009 div_busy, divu_busy  in  1 each  busy flags from the signed and unsigned dividers.
REQ-010 mul_start, mulu_start, div_start, divu_start  out  1 each  one-cycle launch pulses to the units.
REQ-011 hi_ena, lo_ena  out  1 each  HI and LO register write enables.
REQ-012 hi_sel, lo_sel  out  3 each  HI/LO input select: 000 Rs, 001 DIV, 010 DIVU, 011 MULT, 100 MULTU.
REQ-013 mdu_busy  out  1  high whenever state != IDLE; the controller stalls on it.
REQ-014 op_done  out  1  one-cycle pulse, coincident with the HI/LO write.
REQ-015 op_err  out  1  one-cycle pulse on an illegal op, a timeout, or a divide-by-zero trap.

Function
REQ-016 The FSM states are IDLE, LAUNCH, WAIT, WB and ERR; the state register is 3 bits.
REQ-017 IDLE: on acceptance, op is latched; MULT/MULTU/DIV/DIVU go to LAUNCH, MTHI/MTLO go to WB, and an illegal op goes to ERR.
REQ-018 LAUNCH lasts exactly one cycle and asserts the single start output matching the latched op, then goes to WAIT with the timeout counter cleared.
REQ-019 WAIT: the counter increments each cycle; completion is never evaluated in the first WAIT cycle, which masks stale flags.
REQ-020 Completion is mul_done=1 for MULT, mulu_done=1 for MULTU, div_busy=0 for DIV and divu_busy=0 for DIVU.
REQ-021 On completion, WAIT goes to WB.
REQ-022 If the counter reaches TIMEOUT-1 without completion, WAIT goes to ERR.
REQ-023 If completion and timeout occur in the same cycle, completion wins.
REQ-024 WB lasts one cycle: hi_ena, lo_ena and op_done are asserted; MTHI asserts hi_ena only and MTLO asserts lo_ena only.
REQ-025 hi_sel and lo_sel are driven from the latched op (MTHI/MTLO give 000) in every state, and are 000 in IDLE.
REQ-026 ERR lasts one cycle: op_err is pulsed, no HI/LO write occurs, and the FSM returns to IDLE.
REQ-027 WB goes to IDLE; req_valid during any non-IDLE state is ignored and is not queued.
REQ-028 Latency: MTHI/MTLO write in cycle A+1 and req_ready returns in A+2, where A is the acceptance cycle.
REQ-029 Latency: for MULT/MULTU/DIV/DIVU, start is in A+1 and the write is in C+1, where C is the first cycle completion is seen, with C >= A+3.
REQ-030 Only one start output is high in any cycle, and start outputs are high only in LAUNCH.

Reset
REQ-031 While rst=1, the state is IDLE, the counter is 0, the latched op is 000, all outputs are 0, hi_sel and lo_sel are 000, and req_ready is 1.
REQ-032 Reset asserted mid-operation aborts immediately with no HI/LO write; in-flight unit results are discarded.

Configuration
REQ-033 With macro MDU_DIV0_TRAP_EN defined, a DIV/DIVU accepted with divisor_zero=1 goes directly to ERR without a start pulse and pulses op_err in A+1.
REQ-034 Without MDU_DIV0_TRAP_EN, divisor_zero is ignored; DIV/DIVU always launch, and op_err reports only illegal ops and timeouts.

Verification
REQ-035 MTHI accepted at cycle 0: hi_ena=1, lo_ena=0, hi_sel=000 and op_done=1 in cycle 1; req_ready=1 in cycle 2.
REQ-036 MULTU at cycle 0 with mulu_done held 1 beforehand, then dropped in cycle 1 and raised in cycle 6: mulu_start in cycle 1; hi_ena=lo_ena=1 with sel=100 in cycle 7, not earlier.
REQ-037 DIV with div_busy never falling and TIMEOUT=8: div_start in cycle 1; op_err in cycle 10; no hi_ena or lo_ena at any point.
REQ-038 req_op=111: op_err in cycle 1, no start pulse, no write; a back-to-back MTLO request is accepted in cycle 2.
REQ-039 DIVU with divisor_zero=1: with MDU_DIV0_TRAP_EN, op_err in cycle 1 and no divu_start; without it, divu_start in cycle 1.
REQ-040 rst pulsed in cycle 3 of a MULT WAIT: all outputs are 0 and req_ready=1 during reset; there is no write after release.
